// File: rtl/pipelined_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared types and constants for the pipelined control unit.
//                This package holds the control bundle struct, the
//                instruction-class and access-size codes, the NOP bundle,
//                and the decode/condition helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

  // Instruction class, taken from IR[27:25]
  localparam logic [2:0] CLS_DP_SHIFT = 3'b000;
  localparam logic [2:0] CLS_DP_IMM   = 3'b001;
  localparam logic [2:0] CLS_LS_IMM   = 3'b010;
  localparam logic [2:0] CLS_LS_REG   = 3'b011;
  localparam logic [2:0] CLS_BRANCH   = 3'b101;

  // Memory access size
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;

  // ALU opcodes used for load/store address generation
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;

  typedef struct packed {
    logic [3:0] opcode;
    logic       se;
    logic       li;
    logic       s;
    logic       b;
    logic       bl;
    logic       rf;
    logic       mem_en;
    logic       rw;
    logic [1:0] size;
    logic       valid;
    logic [3:0] cond;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t NOP_BUNDLE = '0;

  // TST/TEQ/CMP/CMN (1000..1011) only set flags and never write a register
  function automatic logic dp_writes_rf(input logic [3:0] op);
    return op[3:2] != 2'b10;
  endfunction

  // ARM condition-code check; nzcv = {N, Z, C, V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c && !z;
      4'h9:    return !c || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_control_unit_if
//  Description : Bundle of the control-unit signals. The master modport is
//                the instruction source / observer side. The slave modport is
//                the control unit itself.
//                Master drives : ir_in, stall, flush, flags_in
//                Slave drives  : ex_* (EX controls), mem_* (MEM controls),
//                                wb_* (WB controls), retire_cnt, bubble_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ir_in;
  logic             stall;
  logic             flush;
  logic [3:0]       flags_in;
  logic [3:0]       ex_opcode;
  logic             ex_se;
  logic             ex_li;
  logic             ex_s;
  logic             ex_b;
  logic             ex_bl;
  logic             ex_valid;
  logic             mem_en;
  logic             mem_rw;
  logic [1:0]       mem_size;
  logic             wb_rf;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output ir_in, stall, flush, flags_in,
    input  ex_opcode, ex_se, ex_li, ex_s, ex_b, ex_bl, ex_valid,
           mem_en, mem_rw, mem_size, wb_rf, wb_valid, retire_cnt, bubble_cnt
  );

  modport slave (
    input  ir_in, stall, flush, flags_in,
    output ex_opcode, ex_se, ex_li, ex_s, ex_b, ex_bl, ex_valid,
           mem_en, mem_rw, mem_size, wb_rf, wb_valid, retire_cnt, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_control_unit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cu_decode
//  Description : Purely combinational ID-stage decoder that maps IR to a
//                ctrl_bundle_t.
//                ir_i     : instruction word in ID (0 means NOP)
//                bundle_o : decoded control bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_decode
  import cu_pkg::*;
(
  input  wire logic [31:0] ir_i,
  output ctrl_bundle_t     bundle_o
);

  // Operand fields are consumed elsewhere in the datapath
  wire w_unused_ir = ^{ir_i[19:8], ir_i[6:5], ir_i[3:0]};

  always_comb begin
    bundle_o = NOP_BUNDLE;
    if (ir_i != 32'b0) begin
      case (ir_i[27:25])
        CLS_DP_SHIFT: begin
          bundle_o.valid = 1'b1;
          bundle_o.cond  = ir_i[31:28];
          bundle_o.se    = 1'b1;
          if (ir_i[7] && ir_i[4]) begin
            // Halfword transfer lives in the DP-shift encoding space
            bundle_o.mem_en = 1'b1;
            bundle_o.rw     = ir_i[20];
            bundle_o.size   = SIZE_HALF;
            bundle_o.opcode = ir_i[23] ? OP_ADD : OP_SUB;
            bundle_o.rf     = ir_i[20];
          end else begin
            bundle_o.opcode = ir_i[24:21];
            bundle_o.s      = ir_i[20];
            bundle_o.rf     = dp_writes_rf(ir_i[24:21]);
          end
        end
        CLS_DP_IMM: begin
          bundle_o.valid  = 1'b1;
          bundle_o.cond   = ir_i[31:28];
          bundle_o.opcode = ir_i[24:21];
          bundle_o.s      = ir_i[20];
          bundle_o.rf     = dp_writes_rf(ir_i[24:21]);
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          bundle_o.valid  = 1'b1;
          bundle_o.cond   = ir_i[31:28];
          bundle_o.li     = 1'b1;
          bundle_o.mem_en = 1'b1;
          bundle_o.rw     = ir_i[20];
          bundle_o.size   = ir_i[22] ? SIZE_BYTE : SIZE_WORD;
          bundle_o.opcode = ir_i[23] ? OP_ADD : OP_SUB;
          bundle_o.rf     = ir_i[20];
        end
        CLS_BRANCH: begin
          bundle_o.valid = 1'b1;
          bundle_o.cond  = ir_i[31:28];
          bundle_o.b     = 1'b1;
          bundle_o.bl    = ir_i[24];
          bundle_o.rf    = ir_i[24];  // link register write
        end
        default: bundle_o = NOP_BUNDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_control_unit
//  Description : ID decode plus the registered control pipeline
//                (EX, MEM_LAT x MEM, WB). It inserts a bubble into EX on stall
//                or flush, and it counts retired instructions and bubbles.
//                clk   : rising-edge clock
//                rst_n : synchronous active-low reset
//                bus   : pipelined_control_unit_if.slave (IR/stall/flush/
//                        flags in; EX/MEM/WB controls and counters out)
//                MEM_LAT (1..4) : number of MEM stages
//                CNT_W          : counter width; it must match bus CNT_W
//                Optional macro : CU_COND_EVAL_EN (condition evaluation in EX)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input wire logic                 clk,
  input wire logic                 rst_n,
  pipelined_control_unit_if.slave  bus
);

  ctrl_bundle_t     id_w;
  ctrl_bundle_t     ex_d, ex_q;
  ctrl_bundle_t     mem_in_w;
  logic             pass_w;
  logic             cond_kill_w;
  logic             wb_rf_q, wb_valid_q;
  logic [CNT_W-1:0] retire_d, retire_q;
  logic [CNT_W-1:0] bubble_d, bubble_q;

  cu_decode u_decode (
    .ir_i     (bus.ir_in),
    .bundle_o (id_w)
  );

  assign ex_d = (bus.stall || bus.flush) ? NOP_BUNDLE : id_w;

`ifdef CU_COND_EVAL_EN
  assign pass_w = cond_pass(ex_q.cond, bus.flags_in);
`else
  assign pass_w = 1'b1;
  wire w_unused_flags = ^bus.flags_in;
`endif

  // A failed condition turns the instruction into a NOP as it leaves EX
  assign cond_kill_w = ex_q.valid && !pass_w;
  assign mem_in_w    = cond_kill_w ? NOP_BUNDLE : ex_q;

  assign bubble_d = bubble_q + CNT_W'(bus.stall || bus.flush) + CNT_W'(cond_kill_w);
  assign retire_d = retire_q + CNT_W'(wb_valid_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= NOP_BUNDLE;
      bubble_q <= '0;
      retire_q <= '0;
    end else begin
      ex_q     <= ex_d;
      bubble_q <= bubble_d;
      retire_q <= retire_d;
    end
  end

  for (genvar k = 0; k < MEM_LAT; k++) begin : g_mem
    ctrl_bundle_t stage_d;
    ctrl_bundle_t stage_q;
    if (k == 0) begin : g_head
      assign stage_d = mem_in_w;
    end else begin : g_tail
      assign stage_d = g_mem[k-1].stage_q;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) stage_q <= NOP_BUNDLE;
      else        stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_rf_q    <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      wb_rf_q    <= g_mem[MEM_LAT-1].stage_q.rf;
      wb_valid_q <= g_mem[MEM_LAT-1].stage_q.valid;
    end
  end

  // Only rf/valid continue past the last MEM stage
  wire w_unused_mem = ^g_mem[MEM_LAT-1].stage_q;

  assign bus.ex_opcode  = ex_q.opcode;
  assign bus.ex_se      = ex_q.se;
  assign bus.ex_li      = ex_q.li;
  assign bus.ex_s       = ex_q.s;
  assign bus.ex_b       = ex_q.b  && pass_w;
  assign bus.ex_bl      = ex_q.bl && pass_w;
  assign bus.ex_valid   = ex_q.valid;
  assign bus.mem_en     = g_mem[0].stage_q.mem_en;
  assign bus.mem_rw     = g_mem[0].stage_q.rw;
  assign bus.mem_size   = g_mem[0].stage_q.size;
  assign bus.wb_rf      = wb_rf_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.retire_cnt = retire_q;
  assign bus.bubble_cnt = bubble_q;

endmodule
`default_nettype wire
